// File: rtl/pll_lock_rstgen.sv
// rtl/pll_lock_rstgen.sv - lock-qualified core reset sequencer driven by PLL lock
//
// Synchronizes the PLL lock indication, then releases the core reset only after
// lock has stayed high for LOCK_WAIT cycles followed by RST_HOLD cycles.
// Any loss of lock in RUN re-asserts the core reset and is recorded for debug.
//
// Ports:
//   clk            in   1  system clock (PLL output)
//   rst_n          in   1  board reset, asynchronous assert, active-low
//   pll_lock       in   1  PLL lock, asynchronous to clk
//   cpu_rst_n      out  1  core reset, active-low, registered
//   lock_lost      out  1  sticky flag, set on first lock loss in RUN
//   lock_loss_cnt  out  8  lock losses seen in RUN, saturating at 255
//   rsg_state      out  2  current FSM state (0 WAIT_LOCK, 1 STABLE, 2 HOLD, 3 RUN)

module pll_lock_rstgen #(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_WAIT   = 16,
    parameter int RST_HOLD    = 8,
    parameter bit LOCK_BYPASS = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    output logic       cpu_rst_n,
    output logic       lock_lost,
    output logic [7:0] lock_loss_cnt,
    output logic [1:0] rsg_state
);

    localparam int MAX_CNT = (LOCK_WAIT > RST_HOLD) ? LOCK_WAIT : RST_HOLD;
    localparam int CW      = (MAX_CNT <= 1) ? 1 : $clog2(MAX_CNT);

    localparam logic [CW-1:0] LW_LAST = CW'(LOCK_WAIT - 1);
    localparam logic [CW-1:0] RH_LAST = CW'(RST_HOLD - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_lock_in;
    logic                   w_lock_s;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_cnt_nxt;
    logic                   w_loss_evt;

    logic                   r_cpu_rst_n;
    logic                   r_lock_lost;
    logic [7:0]             r_loss_cnt;

    // In bypass the lock source is a constant, but it still travels through the
    // synchronizer so release timing is identical to a real locked PLL.
    assign w_lock_in = LOCK_BYPASS ? 1'b1 : pll_lock;
    assign w_lock_s  = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], w_lock_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= WAIT_LOCK;
            r_cnt       <= '0;
            r_cpu_rst_n <= 1'b0;
            r_lock_lost <= 1'b0;
            r_loss_cnt  <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            // High exactly while the registered state is RUN.
            r_cpu_rst_n <= (w_state_nxt == RUN);
            if (w_loss_evt) begin
                r_lock_lost <= 1'b1;
                if (r_loss_cnt != 8'hFF) begin
                    r_loss_cnt <= r_loss_cnt + 8'd1;
                end
            end
        end
    end

    // Lock drop is tested before the terminal count so it always wins.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_loss_evt  = 1'b0;
        case (r_state)
            WAIT_LOCK: begin
                if (w_lock_s) begin
                    w_state_nxt = STABLE;
                    w_cnt_nxt   = '0;
                end
            end
            STABLE: begin
                if (!w_lock_s) begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == LW_LAST) begin
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            HOLD: begin
                if (!w_lock_s) begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == RH_LAST) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            RUN: begin
                if (!w_lock_s) begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = '0;
                    w_loss_evt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = WAIT_LOCK;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign cpu_rst_n     = r_cpu_rst_n;
    assign lock_lost     = r_lock_lost;
    assign lock_loss_cnt = r_loss_cnt;
    assign rsg_state     = r_state;

endmodule

// File: tb/tb_pll_lock_rstgen.sv
// tb/tb_pll_lock_rstgen.sv - directed self-checking bench for pll_lock_rstgen

module tb_pll_lock_rstgen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pll_lock;
    logic       lock_zero;

    logic       cpu_rst_n;
    logic       lock_lost;
    logic [7:0] lock_loss_cnt;
    logic [1:0] rsg_state;

    logic       b_cpu_rst_n;
    logic       b_lock_lost;
    logic [7:0] b_lock_loss_cnt;
    logic [1:0] b_rsg_state;

    logic       s_cpu_rst_n;
    logic       s_lock_lost;
    logic [7:0] s_lock_loss_cnt;
    logic [1:0] s_rsg_state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pll_lock_rstgen dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pll_lock      (pll_lock),
        .cpu_rst_n     (cpu_rst_n),
        .lock_lost     (lock_lost),
        .lock_loss_cnt (lock_loss_cnt),
        .rsg_state     (rsg_state)
    );

    pll_lock_rstgen #(.LOCK_BYPASS(1'b1)) dut_byp (
        .clk           (clk),
        .rst_n         (rst_n),
        .pll_lock      (lock_zero),
        .cpu_rst_n     (b_cpu_rst_n),
        .lock_lost     (b_lock_lost),
        .lock_loss_cnt (b_lock_loss_cnt),
        .rsg_state     (b_rsg_state)
    );

    pll_lock_rstgen #(.SYNC_STAGES(3), .LOCK_WAIT(1), .RST_HOLD(1)) dut_small (
        .clk           (clk),
        .rst_n         (rst_n),
        .pll_lock      (pll_lock),
        .cpu_rst_n     (s_cpu_rst_n),
        .lock_lost     (s_lock_lost),
        .lock_loss_cnt (s_lock_loss_cnt),
        .rsg_state     (s_rsg_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_state(input int n);
        if (n <= 2)       return 0;
        else if (n <= 18) return 1;
        else if (n <= 26) return 2;
        else              return 3;
    endfunction

    initial begin
        int e;
        int w;
        int exp_cnt;

        rst_n     = 1'b0;
        pll_lock  = 1'b1;
        lock_zero = 1'b0;
        #12;
        chk("rst_cpu_rst_n", cpu_rst_n, 0);
        chk("rst_lock_lost", lock_lost, 0);
        chk("rst_loss_cnt", lock_loss_cnt, 0);
        chk("rst_state", rsg_state, 0);

        // Release with lock held high: RUN at edge 27.
        tick();
        rst_n = 1'b1;
        for (int n = 1; n <= 27; n++) begin
            tick();
            chk($sformatf("rel_state_e%0d", n), rsg_state, exp_state(n));
            chk($sformatf("rel_cpu_e%0d", n), cpu_rst_n, (n >= 27) ? 1 : 0);
            if (n == 26 || n == 27)
                chk($sformatf("byp_cpu_e%0d", n), b_cpu_rst_n, (n >= 27) ? 1 : 0);
            if (n == 5 || n == 6)
                chk($sformatf("small_cpu_e%0d", n), s_cpu_rst_n, (n >= 6) ? 1 : 0);
        end

        // Fresh sequence, lock drops for 3 cycles while STABLE cnt=10.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (13) tick();
        e = 13;
        pll_lock = 1'b0;
        tick(); e++;
        tick(); e++;
        chk("drop_state_e15", rsg_state, 1);
        tick(); e++;
        chk("drop_state_e16", rsg_state, 0);
        pll_lock = 1'b1;
        while (e < 42) begin
            tick(); e++;
        end
        chk("relock_cpu_e42", cpu_rst_n, 0);
        chk("byp_cpu_e42", b_cpu_rst_n, 1);
        tick(); e++;
        chk("relock_cpu_e43", cpu_rst_n, 1);
        chk("relock_state_e43", rsg_state, 3);
        chk("relock_loss_cnt", lock_loss_cnt, 0);
        chk("relock_lost", lock_lost, 0);

        // Loss in RUN: pll_lock low before edge 46, core reset falls at 48.
        tick(); e++;
        tick(); e++;
        pll_lock = 1'b0;
        tick(); e++;
        pll_lock = 1'b1;
        tick(); e++;
        chk("loss_cpu_e47", cpu_rst_n, 1);
        chk("loss_lost_e47", lock_lost, 0);
        tick(); e++;
        chk("loss_cpu_e48", cpu_rst_n, 0);
        chk("loss_lost_e48", lock_lost, 1);
        chk("loss_cnt_e48", lock_loss_cnt, 1);
        chk("loss_state_e48", rsg_state, 0);
        tick(); e++;
        chk("loss_state_e49", rsg_state, 1);
        while (e < 72) begin
            tick(); e++;
        end
        chk("loss_relock_cpu_e72", cpu_rst_n, 0);
        tick(); e++;
        chk("loss_relock_cpu_e73", cpu_rst_n, 1);
        chk("byp_loss_cnt", b_lock_loss_cnt, 0);

        // Losses 2..260: counter saturates at 255.
        for (int i = 2; i <= 260; i++) begin
            pll_lock = 1'b0;
            tick();
            pll_lock = 1'b1;
            w = 0;
            while (cpu_rst_n !== 1'b0 && w < 5) begin
                tick(); w++;
            end
            chk($sformatf("sat_fall_%0d", i), cpu_rst_n, 0);
            exp_cnt = (i > 255) ? 255 : i;
            chk($sformatf("sat_cnt_%0d", i), lock_loss_cnt, exp_cnt);
            w = 0;
            while (cpu_rst_n !== 1'b1 && w < 40) begin
                tick(); w++;
            end
            chk($sformatf("sat_rise_%0d", i), cpu_rst_n, 1);
        end
        chk("sat_lost", lock_lost, 1);
        chk("byp_sat_loss_cnt", b_lock_loss_cnt, 0);
        chk("byp_sat_cpu", b_cpu_rst_n, 1);

        // Asynchronous reset between edges while in RUN.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cpu", cpu_rst_n, 0);
        chk("arst_lost", lock_lost, 0);
        chk("arst_cnt", lock_loss_cnt, 0);
        chk("arst_state", rsg_state, 0);

        // Asynchronous reset mid-HOLD.
        tick();
        rst_n = 1'b1;
        repeat (22) tick();
        chk("hold_state_e22", rsg_state, 2);
        chk("hold_cpu_e22", cpu_rst_n, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("hold_arst_state", rsg_state, 0);
        chk("hold_arst_cpu", cpu_rst_n, 0);
        chk("hold_arst_byp_cpu", b_cpu_rst_n, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
